mem_bus_interface: RTL and testbench
====================================

MEM_BUS_INTERFACE -- requirements
Module: mem_bus_interface

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width.
REQ-003 Parameter WAIT_MAX, default 15, SHALL set the maximum number of wait cycles before a bus timeout (range 1..255).
REQ-004 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-005 i_Clk  input  1  system clock; all state changes on the rising edge.
REQ-006 i_Reset  input  1  synchronous active-high reset.
REQ-007 i_Address_Out  input  1  microcode request to latch i_Address for a new memory cycle.
REQ-008 i_Bus_Out  input  1  microcode request for a CPU-to-memory write using i_Data.
REQ-009 i_Bus_In  input  1  microcode request for a memory-to-CPU read.
REQ-010 i_Address  input  ADDR_W  address from the register file.
REQ-011 i_Data  input  DATA_W  write data from the register file.
REQ-012 o_Data  output  DATA_W  captured read data.
REQ-013 o_Data_Valid  output  1  one-cycle pulse when o_Data has been updated.
REQ-014 o_Mem_Addr  output  ADDR_W  registered memory address.
REQ-015 o_Mem_WData  output  DATA_W  registered memory write data.
REQ-016 o_Mem_Rd, o_Mem_Wr  output  1 each  registered memory read and write strobes.
REQ-017 i_Mem_RData  input  DATA_W  memory read data.
REQ-018 i_Mem_Ready  input  1  memory completion; sampled only in ACCESS.
REQ-019 o_Stall  output  1  freezes the CPU cycle-step counter.
REQ-020 o_Bus_Error  output  1  one-cycle error pulse.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ADDR and ACCESS, and SHALL encode them as 2 bits.
REQ-022 In IDLE, when i_Address_Out=1, the block SHALL load o_Mem_Addr<=i_Address and move to ADDR on the next edge; any bus strobes in the same cycle SHALL be ignored.
REQ-023 In ADDR, when i_Bus_Out=1 and i_Bus_In=0, the block SHALL set o_Mem_WData<=i_Data, set o_Mem_Wr<=1, clear the wait counter and move to ACCESS.
REQ-024 In ADDR, when i_Bus_In=1 and i_Bus_Out=0, the block SHALL set o_Mem_Rd<=1, clear the wait counter and move to ACCESS.
REQ-025 In ADDR, when i_Bus_In=1 and i_Bus_Out=1, the block SHALL pulse o_Bus_Error for one cycle, assert no memory strobe and return to IDLE.
REQ-026 In ADDR, when neither bus strobe is set and i_Address_Out=1, the block SHALL re-latch o_Mem_Addr and stay in ADDR; when no input is set, it SHALL hold state.
REQ-027 In ADDR, a bus strobe SHALL take priority over a simultaneous i_Address_Out, and no re-latch SHALL occur.
REQ-028 In ACCESS, o_Stall SHALL equal ~i_Mem_Ready combinationally; o_Stall SHALL be 0 in every other state.
REQ-029 In ACCESS, when i_Mem_Ready=1, the block SHALL clear both strobes and return to IDLE; on a read it SHALL also set o_Data<=i_Mem_RData and pulse o_Data_Valid for one cycle.
REQ-030 In ACCESS, when i_Mem_Ready=0, the 8-bit wait counter SHALL increment by 1.
REQ-031 If the wait counter equals WAIT_MAX-1 while i_Mem_Ready=0, the block SHALL clear both strobes, pulse o_Bus_Error, leave o_Data unchanged and return to IDLE.
REQ-032 Zero-wait memory SHALL complete each access in 3 clocks: IDLE to ADDR, ADDR to ACCESS, ACCESS to IDLE.
REQ-033 All i_Address_Out, i_Bus_In and i_Bus_Out inputs SHALL be ignored in ACCESS.
REQ-034 o_Mem_Rd and o_Mem_Wr SHALL never be 1 at the same time.
REQ-035 o_Mem_Addr and o_Mem_WData SHALL hold their values outside the loads defined above.

Reset
REQ-036 When i_Reset=1 at an edge, the block SHALL force state IDLE and clear to 0 all of the following: o_Mem_Addr, o_Mem_WData, o_Mem_Rd, o_Mem_Wr, o_Data, o_Data_Valid, o_Bus_Error and the wait counter; o_Stall SHALL read 0 after that edge.
REQ-037 Reset SHALL take priority over every other input, including during ACCESS, so that strobes drop on the same edge.

Verification
REQ-038 Zero-wait write: address 0xC000, data 0x5A, i_Bus_Out, i_Mem_Ready=1 -> o_Mem_Addr=0xC000, o_Mem_WData=0x5A, o_Mem_Wr high for exactly 1 cycle, o_Stall stays 0.
REQ-039 Read with 2 wait cycles: address 0xFF80, i_Bus_In, i_Mem_Ready low for 2 cycles then high with i_Mem_RData=0xA7 -> o_Stall high for 2 cycles, then o_Data=0xA7 and a single o_Data_Valid pulse.
REQ-040 Timeout: WAIT_MAX=4, read with i_Mem_Ready held 0 -> o_Mem_Rd drops after 4 ACCESS cycles, one o_Bus_Error pulse, o_Data unchanged, FSM in IDLE.
REQ-041 Conflict: i_Bus_In=1 and i_Bus_Out=1 in ADDR -> one o_Bus_Error pulse, o_Mem_Rd=o_Mem_Wr=0, FSM in IDLE.
REQ-042 Reset mid-access: i_Reset asserted in the 2nd ACCESS wait cycle of a write to 0x1234 -> all outputs 0 on the next edge; a following read from 0x0100 completes normally.
REQ-043 Re-latch and priority: i_Address_Out with 0x1000, then i_Address_Out with 0x2000, then i_Bus_In together with i_Address_Out carrying 0x3000 -> read issued to 0x2000.

Source files
------------

// File: rtl/mem_bus_interface_if.sv
// Bus bundle between the CPU microcode/register file and the memory bus controller.
interface mem_bus_interface_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              i_Address_Out;
    logic              i_Bus_Out;
    logic              i_Bus_In;
    logic [ADDR_W-1:0] i_Address;
    logic [DATA_W-1:0] i_Data;
    logic [DATA_W-1:0] o_Data;
    logic              o_Data_Valid;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic [DATA_W-1:0] o_Mem_WData;
    logic              o_Mem_Rd;
    logic              o_Mem_Wr;
    logic [DATA_W-1:0] i_Mem_RData;
    logic              i_Mem_Ready;
    logic              o_Stall;
    logic              o_Bus_Error;

    modport master (
        input  i_Address_Out, i_Bus_Out, i_Bus_In, i_Address, i_Data,
        input  i_Mem_RData, i_Mem_Ready,
        output o_Data, o_Data_Valid, o_Mem_Addr, o_Mem_WData,
        output o_Mem_Rd, o_Mem_Wr, o_Stall, o_Bus_Error
    );

    modport slave (
        output i_Address_Out, i_Bus_Out, i_Bus_In, i_Address, i_Data,
        output i_Mem_RData, i_Mem_Ready,
        input  o_Data, o_Data_Valid, o_Mem_Addr, o_Mem_WData,
        input  o_Mem_Rd, o_Mem_Wr, o_Stall, o_Bus_Error
    );
endinterface

// File: rtl/mem_bus_interface.sv
// Memory bus controller: latches an address, issues one read or write strobe,
// waits for memory ready with a bounded timeout, and stalls the CPU meanwhile.
module mem_bus_interface #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    mem_bus_interface_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              dvld_q, dvld_d;
    logic              err_q, err_d;
    logic [7:0]        wcnt_q, wcnt_d;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dvld_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            dvld_q  <= dvld_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        dvld_d  = 1'b0;
        err_d   = 1'b0;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_Address_Out) begin
                    addr_d  = bus.i_Address;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Bus strobes win over a simultaneous address re-latch.
                if (bus.i_Bus_In && bus.i_Bus_Out) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus.i_Bus_Out) begin
                    wdata_d = bus.i_Data;
                    wr_d    = 1'b1;
                    wcnt_d  = '0;
                    state_d = ACCESS;
                end else if (bus.i_Bus_In) begin
                    rd_d    = 1'b1;
                    wcnt_d  = '0;
                    state_d = ACCESS;
                end else if (bus.i_Address_Out) begin
                    addr_d  = bus.i_Address;
                end
            end
            ACCESS: begin
                if (bus.i_Mem_Ready) begin
                    if (rd_q) begin
                        data_d = bus.i_Mem_RData;
                        dvld_d = 1'b1;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_Data       = data_q;
    assign bus.o_Data_Valid = dvld_q;
    assign bus.o_Mem_Addr   = addr_q;
    assign bus.o_Mem_WData  = wdata_q;
    assign bus.o_Mem_Rd     = rd_q;
    assign bus.o_Mem_Wr     = wr_q;
    assign bus.o_Bus_Error  = err_q;
    assign bus.o_Stall      = (state_q == ACCESS) && !bus.i_Mem_Ready;
endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed bench for mem_bus_interface (WAIT_MAX=4) with immediate-assertion checks.
module tb_mem_bus_interface;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mem_bus_interface_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mem_bus_interface #(.ADDR_W(16), .DATA_W(8), .WAIT_MAX(4)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus.master)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_Out     = 1'b0;
        bus.i_Bus_In      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.i_Address   = 16'h0;
        bus.i_Data      = 8'h0;
        bus.i_Mem_RData = 8'h0;
        bus.i_Mem_Ready = 1'b0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_addr",  bus.o_Mem_Addr, 16'h0);
        chk("rst_wdata", 16'(bus.o_Mem_WData), 16'h0);
        chk("rst_rd",    16'(bus.o_Mem_Rd), 16'h0);
        chk("rst_wr",    16'(bus.o_Mem_Wr), 16'h0);
        chk("rst_data",  16'(bus.o_Data), 16'h0);
        chk("rst_dvld",  16'(bus.o_Data_Valid), 16'h0);
        chk("rst_err",   16'(bus.o_Bus_Error), 16'h0);
        chk("rst_stall", 16'(bus.o_Stall), 16'h0);

        // Zero-wait write to 0xC000; bus strobe alongside the address latch is ignored
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'hC000;
        bus.i_Bus_Out     = 1'b1;
        bus.i_Data        = 8'h11;
        bus.i_Mem_Ready   = 1'b1;
        step();
        chk("wr_addr", bus.o_Mem_Addr, 16'hC000);
        chk("wr_ign_strobe", 16'(bus.o_Mem_Wr), 16'h0);
        bus.i_Address_Out = 1'b0;
        bus.i_Data        = 8'h5A;
        step();
        chk("wr_strobe", 16'(bus.o_Mem_Wr), 16'h1);
        chk("wr_rd_low", 16'(bus.o_Mem_Rd), 16'h0);
        chk("wr_wdata",  16'(bus.o_Mem_WData), 16'h5A);
        chk("wr_stall",  16'(bus.o_Stall), 16'h0);
        idle_inputs();
        step();
        chk("wr_strobe_drop", 16'(bus.o_Mem_Wr), 16'h0);
        chk("wr_no_dvld", 16'(bus.o_Data_Valid), 16'h0);
        chk("wr_addr_hold", bus.o_Mem_Addr, 16'hC000);
        chk("wr_wdata_hold", 16'(bus.o_Mem_WData), 16'h5A);

        // Read from 0xFF80 with two wait cycles
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'hFF80;
        step();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_In      = 1'b1;
        bus.i_Mem_Ready   = 1'b0;
        bus.i_Mem_RData   = 8'h00;
        step();
        bus.i_Bus_In = 1'b0;
        #1;
        chk("rd_strobe", 16'(bus.o_Mem_Rd), 16'h1);
        chk("rd_addr",   bus.o_Mem_Addr, 16'hFF80);
        chk("rd_stall1", 16'(bus.o_Stall), 16'h1);
        step();
        chk("rd_stall2", 16'(bus.o_Stall), 16'h1);
        chk("rd_no_dvld", 16'(bus.o_Data_Valid), 16'h0);
        step();
        bus.i_Mem_Ready = 1'b1;
        bus.i_Mem_RData = 8'hA7;
        #1;
        chk("rd_stall_rel", 16'(bus.o_Stall), 16'h0);
        step();
        chk("rd_data", 16'(bus.o_Data), 16'hA7);
        chk("rd_dvld", 16'(bus.o_Data_Valid), 16'h1);
        chk("rd_strobe_drop", 16'(bus.o_Mem_Rd), 16'h0);
        step();
        chk("rd_dvld_pulse", 16'(bus.o_Data_Valid), 16'h0);

        // Timeout: ready held low, WAIT_MAX=4
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'h4444;
        step();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_In      = 1'b1;
        bus.i_Mem_Ready   = 1'b0;
        bus.i_Mem_RData   = 8'h11;
        step();
        bus.i_Bus_In = 1'b0;
        chk("to_rd_c1", 16'(bus.o_Mem_Rd), 16'h1);
        step();
        chk("to_rd_c2", 16'(bus.o_Mem_Rd), 16'h1);
        step();
        chk("to_rd_c3", 16'(bus.o_Mem_Rd), 16'h1);
        step();
        chk("to_rd_c4", 16'(bus.o_Mem_Rd), 16'h1);
        chk("to_err_early", 16'(bus.o_Bus_Error), 16'h0);
        chk("to_stall_c4", 16'(bus.o_Stall), 16'h1);
        step();
        chk("to_rd_drop", 16'(bus.o_Mem_Rd), 16'h0);
        chk("to_err", 16'(bus.o_Bus_Error), 16'h1);
        chk("to_data_kept", 16'(bus.o_Data), 16'hA7);
        chk("to_no_dvld", 16'(bus.o_Data_Valid), 16'h0);
        chk("to_stall_idle", 16'(bus.o_Stall), 16'h0);
        bus.i_Bus_In = 1'b1;
        step();
        bus.i_Bus_In = 1'b0;
        chk("to_err_pulse", 16'(bus.o_Bus_Error), 16'h0);
        chk("to_idle_no_rd", 16'(bus.o_Mem_Rd), 16'h0);

        // Conflicting bus strobes in ADDR
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'h5555;
        step();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_In      = 1'b1;
        bus.i_Bus_Out     = 1'b1;
        step();
        chk("cf_err", 16'(bus.o_Bus_Error), 16'h1);
        chk("cf_rd",  16'(bus.o_Mem_Rd), 16'h0);
        chk("cf_wr",  16'(bus.o_Mem_Wr), 16'h0);
        bus.i_Bus_Out = 1'b0;
        step();
        chk("cf_err_pulse", 16'(bus.o_Bus_Error), 16'h0);
        chk("cf_idle_no_rd", 16'(bus.o_Mem_Rd), 16'h0);
        idle_inputs();

        // Reset during the 2nd wait cycle of a write to 0x1234
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'h1234;
        step();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_Out     = 1'b1;
        bus.i_Data        = 8'h77;
        bus.i_Mem_Ready   = 1'b0;
        step();
        bus.i_Bus_Out = 1'b0;
        chk("mr_wr", 16'(bus.o_Mem_Wr), 16'h1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_addr",  bus.o_Mem_Addr, 16'h0);
        chk("mr_wdata", 16'(bus.o_Mem_WData), 16'h0);
        chk("mr_wr_drop", 16'(bus.o_Mem_Wr), 16'h0);
        chk("mr_data",  16'(bus.o_Data), 16'h0);
        chk("mr_err",   16'(bus.o_Bus_Error), 16'h0);
        chk("mr_stall", 16'(bus.o_Stall), 16'h0);
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'h0100;
        step();
        bus.i_Address_Out = 1'b0;
        bus.i_Bus_In      = 1'b1;
        bus.i_Mem_Ready   = 1'b1;
        bus.i_Mem_RData   = 8'h3C;
        step();
        bus.i_Bus_In = 1'b0;
        chk("mr_rd_addr", bus.o_Mem_Addr, 16'h0100);
        chk("mr_rd", 16'(bus.o_Mem_Rd), 16'h1);
        step();
        chk("mr_rd_data", 16'(bus.o_Data), 16'h3C);
        chk("mr_rd_dvld", 16'(bus.o_Data_Valid), 16'h1);

        // Re-latch in ADDR, then bus strobe beats a simultaneous address load
        bus.i_Address_Out = 1'b1;
        bus.i_Address     = 16'h1000;
        step();
        chk("rl_first", bus.o_Mem_Addr, 16'h1000);
        bus.i_Address = 16'h2000;
        step();
        chk("rl_second", bus.o_Mem_Addr, 16'h2000);
        chk("rl_no_rd", 16'(bus.o_Mem_Rd), 16'h0);
        bus.i_Address   = 16'h3000;
        bus.i_Bus_In    = 1'b1;
        bus.i_Mem_Ready = 1'b1;
        bus.i_Mem_RData = 8'h9E;
        step();
        idle_inputs();
        chk("rl_rd", 16'(bus.o_Mem_Rd), 16'h1);
        chk("rl_prio_addr", bus.o_Mem_Addr, 16'h2000);
        step();
        chk("rl_data", 16'(bus.o_Data), 16'h9E);
        chk("rl_addr_hold", bus.o_Mem_Addr, 16'h2000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
